// File: rtl/uart_rx_ram_loader.sv
// UART 8N1 receiver that pairs incoming bytes into 16-bit words (high byte first)
// and writes them sequentially into a 2**ADDR_W-word RAM, stopping when it is full.
module uart_rx_ram_loader #(
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_W       = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              uart_rx,
  input  logic              start,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_din,
  output logic              busy,
  output logic              done,
  output logic              frame_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic             rx_p0;
  logic             rx_p1;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic [7:0]       high_byte;
  logic             phase_lo;

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_p0      <= 1'b1;
      rx_p1      <= 1'b1;
      state      <= IDLE;
      clk_cnt    <= '0;
      bit_idx    <= '0;
      phase_lo   <= 1'b0;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      word_count <= '0;
      done       <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      // synchronizer stage boundary: rx_p1 is the only copy the FSM may look at
      rx_p0  <= uart_rx;
      rx_p1  <= rx_p0;
      ram_en <= 1'b0;
      ram_we <= 1'b0;

      if (ram_we) begin
        ram_addr   <= ram_addr + 1'b1;
        word_count <= word_count + 1'b1;
        if (&ram_addr) done <= 1'b1;
      end

      // Arming wins over the post-write increment; a pulse already on the bus still completes.
      if (start) begin
        state      <= IDLE;
        clk_cnt    <= '0;
        bit_idx    <= '0;
        phase_lo   <= 1'b0;
        ram_addr   <= '0;
        word_count <= '0;
        done       <= 1'b0;
        frame_err  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            clk_cnt <= '0;
            if (!rx_p1) state <= START;
          end
          START: begin
            if (clk_cnt == BIT_MID) begin
              clk_cnt <= '0;
              bit_idx <= '0;
              state   <= rx_p1 ? IDLE : DATA;
            end else begin
              clk_cnt <= clk_cnt + 1'b1;
            end
          end
          DATA: begin
            if (clk_cnt == BIT_LAST) begin
              clk_cnt            <= '0;
              shift_reg[bit_idx] <= rx_p1;
              bit_idx            <= bit_idx + 1'b1;
              if (bit_idx == 3'd7) state <= STOP;
            end else begin
              clk_cnt <= clk_cnt + 1'b1;
            end
          end
          STOP: begin
            if (clk_cnt == BIT_LAST) begin
              clk_cnt <= '0;
              state   <= IDLE;
              if (!rx_p1) begin
                frame_err <= 1'b1;
                phase_lo  <= 1'b0;
              end else if (!phase_lo) begin
                high_byte <= shift_reg;
                phase_lo  <= 1'b1;
              end else begin
                // Pairing continues once full so later pairs stay aligned after a re-arm.
                phase_lo <= 1'b0;
                if (!done) begin
                  ram_din <= {high_byte, shift_reg};
                  ram_en  <= 1'b1;
                  ram_we  <= 1'b1;
                end
              end
            end else begin
              clk_cnt <= clk_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_ram_loader.sv
// Bench for uart_rx_ram_loader: serial byte stimulus, expected RAM writes queued and
// matched against every ram_we pulse.
module tb_uart_rx_ram_loader;

  localparam int CPB    = 16;
  localparam int ADDR_W = 6;

  logic              clk;
  logic              reset;
  logic              uart_rx;
  logic              start;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_din;
  logic              busy;
  logic              done;
  logic              frame_err;
  logic [ADDR_W:0]   word_count;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [15:0]       din;
  } wr_t;

  wr_t sb_q[$];
  int  n_checks   = 0;
  int  n_fail     = 0;
  int  writes_seen = 0;

  uart_rx_ram_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .uart_rx(uart_rx), .start(start),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din),
    .busy(busy), .done(done), .frame_err(frame_err), .word_count(word_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Write monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    wr_t exp_wr;
    if (ram_en || ram_we) begin
      n_checks++;
      if (ram_en !== ram_we) begin
        n_fail++;
        $display("FAIL en_we_pair: ram_en=%0b ram_we=%0b, required equal", ram_en, ram_we);
      end
    end
    if (ram_we === 1'b1) begin
      writes_seen++;
      n_checks++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_write: addr=%0d din=%h, required no write", ram_addr, ram_din);
      end else begin
        exp_wr = sb_q.pop_front();
        if (ram_addr !== exp_wr.addr || ram_din !== exp_wr.din) begin
          n_fail++;
          $display("FAIL write_data: addr=%0d din=%h, required addr=%0d din=%h",
                   ram_addr, ram_din, exp_wr.addr, exp_wr.din);
        end
      end
    end
  end

  task automatic push_wr(input int a, input logic [15:0] d);
    wr_t w;
    w.addr = ADDR_W'(a);
    w.din  = d;
    sb_q.push_back(w);
  endtask

  task automatic hold_bit(input logic v);
    uart_rx = v;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_v);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    hold_bit(stop_v);
    uart_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    n_checks += 8;
    if (ram_en !== 1'b0) begin n_fail++; $display("FAIL rst_ram_en: got %0b, required 0", ram_en); end
    if (ram_we !== 1'b0) begin n_fail++; $display("FAIL rst_ram_we: got %0b, required 0", ram_we); end
    if (ram_addr !== '0) begin n_fail++; $display("FAIL rst_addr: got %0d, required 0", ram_addr); end
    if (ram_din !== 16'h0) begin n_fail++; $display("FAIL rst_din: got %h, required 0000", ram_din); end
    if (word_count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d, required 0", word_count); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b, required 0", busy); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b, required 0", done); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL rst_frame_err: got %0b, required 0", frame_err); end
  endtask

  task automatic test_single_pair();
    push_wr(0, 16'h1234);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    n_checks += 3;
    if (ram_addr !== 6'd1) begin n_fail++; $display("FAIL pair_addr: got %0d, required 1", ram_addr); end
    if (word_count !== 7'd1) begin n_fail++; $display("FAIL pair_count: got %0d, required 1", word_count); end
    if (busy !== 1'b0) begin n_fail++; $display("FAIL pair_busy: got %0b, required 0", busy); end
  endtask

  task automatic test_fill();
    int w0;
    pulse_start();
    for (int i = 0; i < 64; i++) push_wr(i, {8'(2 * i), 8'(2 * i + 1)});
    for (int j = 0; j < 128; j++) send_byte(8'(j), 1'b1);
    n_checks += 3;
    if (done !== 1'b1) begin n_fail++; $display("FAIL fill_done: got %0b, required 1", done); end
    if (ram_addr !== 6'd0) begin n_fail++; $display("FAIL fill_addr: got %0d, required 0", ram_addr); end
    if (word_count !== 7'd64) begin n_fail++; $display("FAIL fill_count: got %0d, required 64", word_count); end
    w0 = writes_seen;
    send_byte(8'h99, 1'b1);
    send_byte(8'h98, 1'b1);
    n_checks += 3;
    if (writes_seen !== w0) begin n_fail++; $display("FAIL full_no_write: got %0d writes, required %0d", writes_seen, w0); end
    if (ram_addr !== 6'd0) begin n_fail++; $display("FAIL full_addr: got %0d, required 0", ram_addr); end
    if (word_count !== 7'd64) begin n_fail++; $display("FAIL full_count: got %0d, required 64", word_count); end
  endtask

  task automatic test_glitch();
    int w0;
    pulse_start();
    w0 = writes_seen;
    uart_rx = 1'b0;
    repeat (4) @(negedge clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge clk);
    n_checks += 4;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %0b, required 0", busy); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL glitch_frame_err: got %0b, required 0", frame_err); end
    if (writes_seen !== w0) begin n_fail++; $display("FAIL glitch_write: got %0d writes, required %0d", writes_seen, w0); end
    if (done !== 1'b0) begin n_fail++; $display("FAIL glitch_done: got %0b, required 0", done); end
  endtask

  task automatic test_frame_err();
    push_wr(0, 16'h1122);
    send_byte(8'hAB, 1'b1);
    send_byte(8'hCD, 1'b0);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    n_checks += 3;
    if (frame_err !== 1'b1) begin n_fail++; $display("FAIL ferr_flag: got %0b, required 1", frame_err); end
    if (ram_addr !== 6'd1) begin n_fail++; $display("FAIL ferr_addr: got %0d, required 1", ram_addr); end
    if (word_count !== 7'd1) begin n_fail++; $display("FAIL ferr_count: got %0d, required 1", word_count); end
  endtask

  task automatic test_start_abort();
    hold_bit(1'b0);
    for (int i = 0; i < 3; i++) hold_bit(1'b1);
    uart_rx = 1'b0;
    repeat (CPB / 2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy_before: got %0b, required 1", busy); end
    pulse_start();
    uart_rx = 1'b1;
    n_checks += 4;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %0b, required 0", busy); end
    if (ram_addr !== 6'd0) begin n_fail++; $display("FAIL abort_addr: got %0d, required 0", ram_addr); end
    if (word_count !== 7'd0) begin n_fail++; $display("FAIL abort_count: got %0d, required 0", word_count); end
    if (frame_err !== 1'b0) begin n_fail++; $display("FAIL abort_frame_err: got %0b, required 0", frame_err); end
    repeat (3 * CPB) @(negedge clk);
    push_wr(0, 16'h55AA);
    send_byte(8'h55, 1'b1);
    send_byte(8'hAA, 1'b1);
    n_checks++;
    if (ram_addr !== 6'd1) begin n_fail++; $display("FAIL abort_pair_addr: got %0d, required 1", ram_addr); end
  endtask

  task automatic test_start_during_write();
    logic found;
    found = 1'b0;
    push_wr(1, 16'hC33C);
    fork
      begin
        send_byte(8'hC3, 1'b1);
        send_byte(8'h3C, 1'b1);
      end
      begin
        for (int i = 0; i < 800 && !found; i++) begin
          @(negedge clk);
          if (ram_we === 1'b1) found = 1'b1;
        end
        if (found) begin
          start = 1'b1;
          @(negedge clk);
          start = 1'b0;
        end
      end
    join
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL sw_timeout: got no write within 800 cycles, required one");
    end else begin
      n_checks += 3;
      if (ram_addr !== 6'd0) begin n_fail++; $display("FAIL sw_addr: got %0d, required 0", ram_addr); end
      if (word_count !== 7'd0) begin n_fail++; $display("FAIL sw_count: got %0d, required 0", word_count); end
      if (ram_we !== 1'b0) begin n_fail++; $display("FAIL sw_we: got %0b, required 0", ram_we); end
    end
  endtask

  task automatic test_reset_mid_stop();
    logic [7:0] b;
    int w0;
    b = 8'h02;
    send_byte(8'h01, 1'b1);
    w0 = writes_seen;
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(b[i]);
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    test_reset();
    repeat (3 * CPB) @(negedge clk);
    n_checks++;
    if (writes_seen !== w0) begin n_fail++; $display("FAIL rst_stop_write: got %0d writes, required %0d", writes_seen, w0); end
    push_wr(0, 16'h0FF0);
    send_byte(8'h0F, 1'b1);
    send_byte(8'hF0, 1'b1);
    n_checks++;
    if (ram_addr !== 6'd1) begin n_fail++; $display("FAIL rst_rearm_addr: got %0d, required 1", ram_addr); end
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    test_reset();
    test_single_pair();
    test_fill();
    test_glitch();
    test_frame_err();
    test_start_abort();
    test_start_during_write();
    test_reset_mid_stop();
    repeat (4) @(negedge clk);
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_writes: got %0d pending, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
